// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
//
// General-purpose register file for the 5-stage MIPS core. It sits at the
// consuming end of the write-back path: it registers the we/waddr/wdata
// triple coming out of the MEM/WB pipeline register. It also provides two
// combinational read ports to the ID stage and keeps a running count of
// committed write-backs.
//
// Register 0 is hardwired to zero. Writes to index 0 are dropped and do
// not count as commits.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   - write-through forwarding. A read of the register being
//               written in the same cycle returns wdata.
//   undefined - reads always return stored contents. The new value is
//               visible one cycle after the write.
//
// Ports:
//   clk     in   1       core clock, rising-edge active
//   rst     in   1       asynchronous reset, active low
//   we      in   1       write enable from write-back
//   waddr   in   ADDR_W  write register index
//   wdata   in   DATA_W  write data
//   re1     in   1       read port 1 enable
//   raddr1  in   ADDR_W  read port 1 index
//   rdata1  out  DATA_W  read port 1 data (combinational)
//   re2     in   1       read port 2 enable
//   raddr2  in   ADDR_W  read port 2 index
//   rdata2  out  DATA_W  read port 2 data (combinational)
//   wr_cnt  out  CNT_W   committed non-zero-index writes since reset (wraps)
// ---------------------------------------------------------------------------
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [CNT_W-1:0]  wr_cnt_q;
    logic [CNT_W-1:0]  wr_cnt_d;
    logic              commit;
    logic              hit1;
    logic              hit2;

    // A write only commits when it targets a real register.
    assign commit   = we && (waddr != '0);
    assign wr_cnt_d = commit ? (wr_cnt_q + CNT_ONE) : wr_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            wr_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            if (commit) begin
                regs_q[waddr] <= wdata;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Same-cycle forwarding of the write-back value. This closes the WB->ID
    // hazard without an external forward path.
    assign hit1 = commit && (raddr1 == waddr);
    assign hit2 = commit && (raddr2 == waddr);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    // Read mux priority: reset, enable, index 0, bypass, storage.
    // Reset gating is combinational, so outputs drop to 0 as soon as rst
    // falls. They do not wait for the storage flops to clear.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_lvl,
        input logic              ren,
        input logic [ADDR_W-1:0] ra,
        input logic              hit,
        input logic [DATA_W-1:0] fwd,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] r;
        r = '0;
        if (!rst_lvl || !ren || (ra == '0)) begin
            r = '0;
        end else if (hit) begin
            r = fwd;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    always_comb begin
        rdata1 = read_port(rst, re1, raddr1, hit1, wdata, regs_q[raddr1]);
        rdata2 = read_port(rst, re2, raddr2, hit2, wdata, regs_q[raddr2]);
    end

    assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic [CNT_W-1:0]  wr_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: plain array of register values plus an integer
    // commit counter reduced modulo 2**CNT_W.
    int unsigned mem [DEPTH];
    int unsigned cnt;

    regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .wr_cnt (wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned model_read(input bit ren, input int unsigned a);
        if (!ren || a == 0) return 0;
        if (BYP && we && waddr != 0 && a == waddr) return wdata;
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = 0;
        cnt = 0;
    endtask

    // One clock cycle with rst high. The bench drives the inputs, checks the
    // combinational reads against the model, takes the edge and updates the
    // model. On entry, time is just after a rising edge.
    task automatic cycle(input string tag, input bit w, input int unsigned wa,
                         input int unsigned wd, input bit r1, input int unsigned a1,
                         input bit r2, input int unsigned a2);
        we = w; waddr = ADDR_W'(wa); wdata = wd;
        re1 = r1; raddr1 = ADDR_W'(a1); re2 = r2; raddr2 = ADDR_W'(a2);
        #1;
        chk({tag, ".rd1"}, rdata1, model_read(r1, a1));
        chk({tag, ".rd2"}, rdata2, model_read(r2, a2));
        chk({tag, ".cnt"}, wr_cnt, cnt);
        @(posedge clk);
        if (w && wa != 0) begin
            mem[wa] = wd;
            cnt = (cnt + 1) % (1 << CNT_W);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b1; raddr1 = 5; re2 = 1'b1; raddr2 = 5;
        @(posedge clk); #1;
        chk("rst.rd1", rdata1, 0);
        chk("rst.rd2", rdata2, 0);
        chk("rst.cnt", wr_cnt, 0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of operation.
        cycle("w5", 1, 5, 32'h1234, 0, 0, 0, 0);
        cycle("r5", 0, 0, 0, 1, 5, 1, 5);
        chk("r5.val", rdata1, 32'h1234);
        rst = 1'b0; #1;
        chk("arst.rd1", rdata1, 0);
        chk("arst.rd2", rdata2, 0);
        chk("arst.cnt", wr_cnt, 0);
        // A write attempted while reset is held must not land.
        we = 1'b1; waddr = 5; wdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        chk("wrst.rd1", rdata1, 0);
        chk("wrst.cnt", wr_cnt, 0);
        model_reset();
        rst = 1'b1; we = 1'b0; #1;
        @(posedge clk); #1;
        cycle("post", 0, 0, 0, 1, 5, 1, 5);
        chk("post.val", rdata1, 0);

        // Basic write and dual-port read.
        cycle("w3", 1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
        cycle("r3", 0, 0, 0, 1, 3, 1, 3);
        chk("r3.p1", rdata1, 32'hDEADBEEF);
        chk("r3.p2", rdata2, 32'hDEADBEEF);
        chk("r3.cnt", wr_cnt, 1);

        // Zero register, including a same-cycle read of index 0.
        cycle("w0", 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0);
        cycle("r0", 0, 0, 0, 1, 0, 1, 3);
        chk("r0.val", rdata1, 0);
        chk("r0.cnt", wr_cnt, 1);

        // Read enable gating.
        cycle("w7", 1, 7, 32'h55AA55AA, 0, 0, 0, 0);
        cycle("g7off", 0, 0, 0, 1, 7, 0, 7);
        chk("g7off.val", rdata2, 0);
        cycle("g7on", 0, 0, 0, 1, 7, 1, 7);
        chk("g7on.val", rdata2, 32'h55AA55AA);

        // Same-cycle read of the register being written.
        cycle("w9a", 1, 9, 32'h1, 0, 0, 0, 0);
        we = 1'b1; waddr = 9; wdata = 32'h2; re1 = 1'b1; raddr1 = 9; re2 = 1'b1; raddr2 = 9;
        #1;
        chk("byp.p1", rdata1, BYP ? 32'h2 : 32'h1);
        chk("byp.p2", rdata2, BYP ? 32'h2 : 32'h1);
        @(posedge clk); #1;
        mem[9] = 32'h2; cnt = (cnt + 1) % (1 << CNT_W);
        cycle("r9", 0, 0, 0, 1, 9, 0, 0);
        chk("r9.val", rdata1, 32'h2);

        // Counter wrap at CNT_W=4, with interleaved index-0 writes.
        rst = 1'b0; #1; model_reset(); rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            cycle("wrap", 1, 1, i, 1, 1, 0, 0);
            if (i % 5 == 2) cycle("wrapz", 1, 0, 32'hFFFF, 1, 0, 1, 1);
            if (i == 14) chk("wrap.15", wr_cnt, 15);
        end
        chk("wrap.0", wr_cnt, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, 3) != 0, $urandom_range(0, DEPTH - 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
